// File: rtl/key_mem_pkg.sv
// Package: key_mem_pkg
//   Shared types and constants for the key-store request front-end and for
//   anything else that needs to agree on the protected key window.
//   - state_e        : front-end FSM states
//   - KEY_PROT_BASE  : byte address of the first protected word
//   - KEY_PROT_WORDS : number of protected words
//   - KEY_DATA_W     : key-store data width
//   - rsp_t          : response record {rdata, err}
package key_mem_pkg;

    localparam logic [31:0] KEY_PROT_BASE  = 32'h0;
    localparam int          KEY_PROT_WORDS = 1;
    localparam int          KEY_DATA_W     = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    typedef struct packed {
        logic [KEY_DATA_W-1:0] rdata;
        logic                  err;
    } rsp_t;

endpackage

// File: rtl/key_mem_access_policy.sv
// Module: key_mem_access_policy
//   Purely combinational access policy for the key store. A request is
//   rejected when its byte address is not word aligned, or when it is a
//   write that hits the protected word window while the store is locked.
//   Reads of the window are always allowed; unlocked writes are allowed so
//   the key can be provisioned.
// Ports:
//   we      in   1       1 = write request
//   addr    in   ADDR_W  byte address
//   locked  in   1       effective lock state
//   reject  out  1       1 = request must not reach the memory
module key_mem_access_policy #(
    parameter int              ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] PROT_BASE  = '0,
    parameter int              PROT_WORDS = 1
) (
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic              locked,
    output logic              reject
);

    localparam logic [ADDR_W-1:0] PROT_LO_WORD = PROT_BASE >> 2;
    localparam logic [ADDR_W-1:0] PROT_NWORDS  = ADDR_W'(PROT_WORDS);

    logic [ADDR_W-1:0] word_idx;
    logic [ADDR_W-1:0] word_off;
    logic              misaligned;
    logic              in_window;

    // Window membership is tested on the word index so that every byte
    // alias of a protected word is caught. Subtracting the base and doing a
    // single unsigned compare covers both bounds (indices below the base
    // wrap to large values).
    assign word_idx   = {2'b00, addr[ADDR_W-1:2]};
    assign word_off   = word_idx - PROT_LO_WORD;
    assign in_window  = (word_off < PROT_NWORDS);
    assign misaligned = (addr[1:0] != 2'b00);

    assign reject = misaligned | (we & locked & in_window);

endmodule

// File: rtl/key_mem_access_ctrl.sv
// Module: key_mem_access_ctrl
//   Request front-end sitting directly in front of the key-store memory.
//   Accepts one valid/ready request at a time, applies the write policy on
//   the protected key window, drives the memory pins and returns read data
//   or an error on a valid/ready response channel.
// Ports:
//   clk, reset                 clock (rising edge), synchronous active-high reset
//   req_valid/req_ready        request handshake
//   req_we/req_addr/req_wdata  request payload
//   rsp_valid/rsp_ready        response handshake
//   rsp_rdata/rsp_err          response payload (rdata is 0 for writes/errors)
//   mem_address/mem_we/mem_wd  memory pins
//   mem_data_out               memory read data (1-cycle registered read)
//   lock/locked                set-only lock request / sticky lock status
//   viol_count                 saturating count of rejected requests
// Latency accept->rsp_valid: read 3, write 2, reject 1.
module key_mem_access_ctrl
    import key_mem_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter logic [ADDR_W-1:0] PROT_BASE  = ADDR_W'(KEY_PROT_BASE),
    parameter int                PROT_WORDS = KEY_PROT_WORDS,
    parameter int                CNT_W      = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_data_out,
    input  logic              lock,
    output logic              locked,
    output logic [CNT_W-1:0]  viol_count
);

    state_e            state_reg;
    logic              locked_reg;
    logic [CNT_W-1:0]  viol_reg;
    rsp_t              rsp_reg;
    logic              rsp_valid_reg;
    logic              we_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic              mem_we_reg;
    logic [DATA_W-1:0] mem_wd_reg;

    logic              locked_eff;
    logic              accept;
    logic              reject;

    // A lock request arriving in the same cycle as an accept must already
    // protect the window, so the policy sees the post-update lock value.
    assign locked_eff = locked_reg | lock;

    // Gated by reset so nothing can be accepted in a reset cycle.
    assign req_ready = (state_reg == IDLE) && !reset;
    assign accept    = req_valid && req_ready;

    key_mem_access_policy #(
        .ADDR_W     (ADDR_W),
        .PROT_BASE  (PROT_BASE),
        .PROT_WORDS (PROT_WORDS)
    ) u_policy (
        .we     (req_we),
        .addr   (req_addr),
        .locked (locked_eff),
        .reject (reject)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            locked_reg    <= 1'b0;
            viol_reg      <= '0;
            rsp_reg       <= '0;
            rsp_valid_reg <= 1'b0;
            we_reg        <= 1'b0;
            mem_addr_reg  <= '0;
            mem_we_reg    <= 1'b0;
            mem_wd_reg    <= '0;
        end else begin
            locked_reg <= locked_eff;
            // Write strobe defaults low; it is raised only on the transition
            // into ISSUE, giving exactly a one-cycle pulse.
            mem_we_reg <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        rsp_reg <= '0;
                        if (reject) begin
                            // Rejected requests never touch the memory pins.
                            rsp_reg.err   <= 1'b1;
                            rsp_valid_reg <= 1'b1;
                            if (viol_reg != {CNT_W{1'b1}}) begin
                                viol_reg <= viol_reg + 1'b1;
                            end
                            state_reg <= RESP;
                        end else begin
                            we_reg       <= req_we;
                            mem_addr_reg <= req_addr;
                            mem_wd_reg   <= req_wdata;
                            mem_we_reg   <= req_we;
                            state_reg    <= ISSUE;
                        end
                    end
                end

                ISSUE: begin
                    if (we_reg) begin
                        rsp_valid_reg <= 1'b1;
                        state_reg     <= RESP;
                    end else begin
                        state_reg <= WAIT;
                    end
                end

                WAIT: begin
                    // Memory sampled the address at the end of ISSUE, so its
                    // registered output is valid during this cycle. The
                    // response record is sized to the key-store data width.
                    rsp_reg.rdata <= KEY_DATA_W'(mem_data_out);
                    rsp_valid_reg <= 1'b1;
                    state_reg     <= RESP;
                end

                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end

                default: state_reg <= IDLE;
            endcase
        end
    end

    assign rsp_valid   = rsp_valid_reg;
    assign rsp_rdata   = DATA_W'(rsp_reg.rdata);
    assign rsp_err     = rsp_reg.err;
    assign mem_address = mem_addr_reg;
    assign mem_we      = mem_we_reg;
    assign mem_wd      = mem_wd_reg;
    assign locked      = locked_reg;
    assign viol_count  = viol_reg;

endmodule

// File: tb/tb_key_mem_access_ctrl.sv
// Testbench for key_mem_access_ctrl: table of directed transactions plus
// hand-written sequences for backpressure, counter saturation and reset
// during an in-flight write. A 32-word memory model sits on the memory pins.
module tb_key_mem_access_ctrl;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_address;
    logic        mem_we;
    logic [31:0] mem_wd;
    logic [31:0] mem_data_out;
    logic        lock;
    logic        locked;
    logic [7:0]  viol_count;

    int tests_run = 0;
    int tests_failed = 0;

    key_mem_access_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .mem_address  (mem_address),
        .mem_we       (mem_we),
        .mem_wd       (mem_wd),
        .mem_data_out (mem_data_out),
        .lock         (lock),
        .locked       (locked),
        .viol_count   (viol_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: 32 words, registered read, word 0 holds the key.
    logic [31:0] mem [32];
    always @(posedge clk) begin
        if (mem_we) mem[mem_address[6:2]] <= mem_wd;
        mem_data_out <= mem[mem_address[6:2]];
    end

    // Write-strobe monitor.
    int          we_pulses;
    logic [31:0] last_we_addr;
    always @(posedge clk) begin
        if (mem_we) begin
            we_pulses    <= we_pulses + 1;
            last_we_addr <= mem_address;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One complete transaction; returns response fields, latency in cycles
    // from accept edge to rsp_valid, and write-strobe activity.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic lk, output logic [31:0] rdata, output logic err,
                          output int lat, output int pulses, output logic [31:0] we_addr);
        int n;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        lock      = lk;
        we_pulses = 0;
        last_we_addr = 32'hFFFF_FFFF;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL accept_timeout: req_ready=%0b, expected 1", req_ready);
            req_valid = 1'b0;
            lock = 1'b0;
            rdata = 'x; err = 1'bx; lat = -1; pulses = -1; we_addr = 'x;
            return;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lock = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid && lat < 20);
        rdata = rsp_rdata;
        err   = rsp_err;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        pulses  = we_pulses;
        we_addr = last_we_addr;
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        lk;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_lat;
        int          exp_pulses;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic [31:0] rd, wa, held;
        logic        er;
        int          lat, pl, bad, nv;

        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        mem[0] = 32'h1035_9987;

        vecs[0] = '{1'b0, 32'h0, 32'h0,         1'b0, 1'b0, 32'h1035_9987, 3, 0};
        vecs[1] = '{1'b1, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0,         2, 1};
        vecs[2] = '{1'b0, 32'h0, 32'h0,         1'b0, 1'b0, 32'hDEAD_BEEF, 3, 0};
        vecs[3] = '{1'b1, 32'h0, 32'h1234_5678, 1'b1, 1'b1, 32'h0,         1, 0};
        vecs[4] = '{1'b0, 32'h0, 32'h0,         1'b0, 1'b0, 32'hDEAD_BEEF, 3, 0};
        vecs[5] = '{1'b1, 32'h3, 32'h1111_1111, 1'b0, 1'b1, 32'h0,         1, 0};
        vecs[6] = '{1'b1, 32'h8, 32'h5,         1'b0, 1'b0, 32'h0,         2, 1};
        vecs[7] = '{1'b0, 32'h8, 32'h0,         1'b0, 1'b0, 32'h5,         3, 0};
        vecs[8] = '{1'b0, 32'h5, 32'h0,         1'b0, 1'b1, 32'h0,         1, 0};
        vecs[9] = '{1'b0, 32'h4, 32'h0,         1'b0, 1'b0, 32'h0,         3, 0};

        reset = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b0; lock = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("ready_in_reset", {31'b0, req_ready}, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_rsp_valid",  {31'b0, rsp_valid}, 32'h0);
        check("rst_rsp_err",    {31'b0, rsp_err},   32'h0);
        check("rst_rsp_rdata",  rsp_rdata,          32'h0);
        check("rst_mem_we",     {31'b0, mem_we},    32'h0);
        check("rst_mem_addr",   mem_address,        32'h0);
        check("rst_mem_wd",     mem_wd,             32'h0);
        check("rst_locked",     {31'b0, locked},    32'h0);
        check("rst_viol",       {24'b0, viol_count}, 32'h0);
        check("rst_ready",      {31'b0, req_ready}, 32'h1);

        for (int i = 0; i < 10; i++) begin
            do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].lk, rd, er, lat, pl, wa);
            $display("[TB] vec %0d we=%0b addr=%h wdata=%h lock=%0b -> err=%0b rdata=%h lat=%0d we_pulses=%0d",
                     i, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].lk, er, rd, lat, pl);
            check($sformatf("vec%0d_err", i),    {31'b0, er}, {31'b0, vecs[i].exp_err});
            check($sformatf("vec%0d_rdata", i),  rd,          vecs[i].exp_rdata);
            check($sformatf("vec%0d_lat", i),    lat,         vecs[i].exp_lat);
            check($sformatf("vec%0d_pulses", i), pl,          vecs[i].exp_pulses);
            if (vecs[i].exp_pulses != 0)
                check($sformatf("vec%0d_we_addr", i), wa, vecs[i].addr);
        end
        check("locked_after_vecs", {31'b0, locked},     32'h1);
        check("viol_after_vecs",   {24'b0, viol_count}, 32'h3);

        // Backpressure: response must hold while rsp_ready stays low.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h8;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        nv = 0;
        while (!rsp_valid && nv < 20) begin
            @(negedge clk);
            nv++;
        end
        held = rsp_rdata;
        check("bp_rdata", held, 32'h5);
        bad = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (!rsp_valid || rsp_rdata !== held || rsp_err !== 1'b0 || req_ready !== 1'b0) bad++;
        end
        $display("[TB] backpressure 4 cycles, unstable cycles=%0d", bad);
        check("bp_stable", bad, 0);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        check("bp_released", {30'b0, rsp_valid, req_ready}, 32'h1);

        // Saturation: 300 misaligned reads.
        for (int k = 0; k < 300; k++) begin
            do_req(1'b0, 32'h2, 32'h0, 1'b0, rd, er, lat, pl, wa);
        end
        $display("[TB] 300 rejects -> viol_count=%h", viol_count);
        check("viol_saturated", {24'b0, viol_count}, 32'h0000_00FF);

        // Reset while a write is in ISSUE: no response must follow.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'hA5A5_A5A5;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("issue_we_high", {31'b0, mem_we}, 32'h1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        bad = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (rsp_valid) bad++;
        end
        $display("[TB] reset during ISSUE -> rsp_valid cycles=%0d locked=%0b viol=%h", bad, locked, viol_count);
        check("midrst_no_rsp", bad, 0);
        check("midrst_locked", {31'b0, locked},     32'h0);
        check("midrst_viol",   {24'b0, viol_count}, 32'h0);
        check("midrst_ready",  {31'b0, req_ready},  32'h1);

        // Unlocked again after reset: provisioning write to word 0 succeeds.
        do_req(1'b1, 32'h0, 32'hCAFE_F00D, 1'b0, rd, er, lat, pl, wa);
        check("reprov_err", {31'b0, er}, 32'h0);
        do_req(1'b0, 32'h0, 32'h0, 1'b0, rd, er, lat, pl, wa);
        $display("[TB] reprovision read -> rdata=%h err=%0b", rd, er);
        check("reprov_rdata", rd, 32'hCAFE_F00D);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
